// File: rtl/riscv_defines.sv
// ---------------------------------------------------------------------------
// riscv_defines
// Shared constants for the hardware-loop block and its neighbours:
//   HWLP_WE_*       bit positions inside the 3-bit hardware-loop write strobe
//   HWLP_REGID_W    width of the loop register-set index
//   CSR_HWLP*       CSR addresses of the hardware-loop registers (0x7B0-0x7B6)
// ---------------------------------------------------------------------------
package riscv_defines;

  localparam int unsigned HWLP_WE_START = 0;
  localparam int unsigned HWLP_WE_END   = 1;
  localparam int unsigned HWLP_WE_CNT   = 2;

  localparam int unsigned HWLP_REGID_W  = 1;

  localparam logic [11:0] CSR_HWLP0_START   = 12'h7B0;
  localparam logic [11:0] CSR_HWLP0_END     = 12'h7B1;
  localparam logic [11:0] CSR_HWLP0_COUNTER = 12'h7B2;
  localparam logic [11:0] CSR_HWLP1_START   = 12'h7B4;
  localparam logic [11:0] CSR_HWLP1_END     = 12'h7B5;
  localparam logic [11:0] CSR_HWLP1_COUNTER = 12'h7B6;

endpackage

// File: rtl/riscv_hwloop_regs_if.sv
// ---------------------------------------------------------------------------
// riscv_hwloop_regs_if
// CSR-side bus of the hardware-loop register file.
//   hwlp_data   write data
//   hwlp_regid  register set selected for the write
//   hwlp_we     one-hot write strobe (start / end / count)
//   hwlp_start  readback of all start addresses
//   hwlp_end    readback of all end addresses
//   hwlp_cnt    readback of all remaining iteration counts
// master: CSR block.  slave: hardware-loop register file.
// ---------------------------------------------------------------------------
interface riscv_hwloop_regs_if #(
  parameter int N_REGSETS = 2,
  parameter int RID_W     = 1
);

  logic [31:0]                 hwlp_data;
  logic [RID_W-1:0]            hwlp_regid;
  logic [2:0]                  hwlp_we;
  logic [N_REGSETS-1:0][31:0]  hwlp_start;
  logic [N_REGSETS-1:0][31:0]  hwlp_end;
  logic [N_REGSETS-1:0][31:0]  hwlp_cnt;

  modport master (
    output hwlp_data, hwlp_regid, hwlp_we,
    input  hwlp_start, hwlp_end, hwlp_cnt
  );

  modport slave (
    input  hwlp_data, hwlp_regid, hwlp_we,
    output hwlp_start, hwlp_end, hwlp_cnt
  );

endinterface

// File: rtl/riscv_hwloop_match.sv
// ---------------------------------------------------------------------------
// riscv_hwloop_match
// Per-set end-address compare and inner-loop-first priority encoder.
//   pc_id_i     PC of the instruction in ID
//   id_valid_i  ID instruction completes this cycle
//   end_i       end address of every set
//   cnt_i       remaining count of every set
//   sel_o       lowest-index matching set
//   match_o     some set matched (sel_o is meaningful)
//   jump_en_o   selected set still has iterations left after this one
// ---------------------------------------------------------------------------
module riscv_hwloop_match #(
  parameter int N_REGSETS = 2,
  parameter int RID_W     = 1
) (
  input  logic [31:0]                pc_id_i,
  input  logic                       id_valid_i,
  input  logic [N_REGSETS-1:0][31:0] end_i,
  input  logic [N_REGSETS-1:0][31:0] cnt_i,
  output logic [RID_W-1:0]           sel_o,
  output logic                       match_o,
  output logic                       jump_en_o
);

  // Scanning from the outermost set down lets the innermost match overwrite
  // any outer one, which gives set 0 priority.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; without that a latch would be inferred.
    sel_o   = '0;
    match_o = 1'b0;
    for (int i = N_REGSETS - 1; i >= 0; i--) begin
      if (id_valid_i && (pc_id_i == end_i[i]) && (cnt_i[i] != 32'd0)) begin
        sel_o   = RID_W'(i);
        match_o = 1'b1;
      end
    end
  end

  // A count of exactly 1 is the last pass: fall through instead of jumping.
  assign jump_en_o = match_o && (cnt_i[sel_o] > 32'd1);

endmodule

// File: rtl/riscv_hwloop_regs.sv
// ---------------------------------------------------------------------------
// riscv_hwloop_regs
// Hardware-loop register file and end-of-loop controller.
//   clk, rst_n      clock, asynchronous active-low reset
//   csr_if          CSR write strobes/data in, start/end/count readback out
//   pc_id_i         PC of the instruction in ID
//   id_valid_i      ID instruction completes this cycle
//   hwlp_jump_o     zero-overhead branch request (combinational)
//   hwlp_target_o   branch target, the selected loop start (0 when idle)
//   hwlp_done_o     one-cycle loop-completed pulse per set; only present when
//                   HWLP_EVENT_COUNT_EN is defined
// ---------------------------------------------------------------------------
module riscv_hwloop_regs
  import riscv_defines::*;
#(
  parameter int N_REGSETS = 2,
  parameter int RID_W     = HWLP_REGID_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  riscv_hwloop_regs_if.slave    csr_if,
  input  logic [31:0]           pc_id_i,
  input  logic                  id_valid_i,
  output logic                  hwlp_jump_o,
  output logic [31:0]           hwlp_target_o
`ifdef HWLP_EVENT_COUNT_EN
  ,
  output logic [N_REGSETS-1:0]  hwlp_done_o
`endif
);

  logic [N_REGSETS-1:0][31:0] start_q, start_d;
  logic [N_REGSETS-1:0][31:0] end_q,   end_d;
  logic [N_REGSETS-1:0][31:0] cnt_q,   cnt_d;

  logic [RID_W-1:0] sel;
  logic             match;
  logic             jump_en;

  riscv_hwloop_match #(
    .N_REGSETS (N_REGSETS),
    .RID_W     (RID_W)
  ) u_match (
    .pc_id_i    (pc_id_i),
    .id_valid_i (id_valid_i),
    .end_i      (end_q),
    .cnt_i      (cnt_q),
    .sel_o      (sel),
    .match_o    (match),
    .jump_en_o  (jump_en)
  );

  // Decrement first, then let CSR writes overwrite, so a count write wins
  // over a same-cycle decrement. A regid with no matching set writes nothing.
  always_comb begin
    start_d = start_q;
    end_d   = end_q;
    cnt_d   = cnt_q;
    if (match) begin
      cnt_d[sel] = cnt_q[sel] - 32'd1;
    end
    for (int i = 0; i < N_REGSETS; i++) begin
      if (int'(csr_if.hwlp_regid) == i) begin
        if (csr_if.hwlp_we[HWLP_WE_START]) start_d[i] = {csr_if.hwlp_data[31:1], 1'b0};
        if (csr_if.hwlp_we[HWLP_WE_END])   end_d[i]   = {csr_if.hwlp_data[31:1], 1'b0};
        if (csr_if.hwlp_we[HWLP_WE_CNT])   cnt_d[i]   = csr_if.hwlp_data;
      end
    end
  end

  // NOTE: the register sets are a handful of flops, not a RAM, so they take
  // the asynchronous reset; a cleared count also disarms every loop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= '0;
      end_q   <= '0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from the same
      // pre-edge values.
      start_q <= start_d;
      end_q   <= end_d;
      cnt_q   <= cnt_d;
    end
  end

  assign csr_if.hwlp_start = start_q;
  assign csr_if.hwlp_end   = end_q;
  assign csr_if.hwlp_cnt   = cnt_q;

  // Jump decision uses the pre-write registers; during reset the counts are
  // cleared, so no set can match.
  assign hwlp_jump_o   = jump_en;
  assign hwlp_target_o = jump_en ? start_q[sel] : 32'd0;

`ifdef HWLP_EVENT_COUNT_EN
  logic [N_REGSETS-1:0] done_d, done_q;

  // Exit means the decrement really takes the count from 1 to 0; a count
  // write to the same set in that cycle cancels it.
  always_comb begin
    done_d = '0;
    if (match && (cnt_q[sel] == 32'd1) &&
        !(csr_if.hwlp_we[HWLP_WE_CNT] && (int'(csr_if.hwlp_regid) == int'(sel)))) begin
      done_d[sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= '0;
    else        done_q <= done_d;
  end

  assign hwlp_done_o = done_q;
`endif

endmodule

// File: tb/tb_riscv_hwloop_regs.sv
// ---------------------------------------------------------------------------
// tb_riscv_hwloop_regs
// Directed scoreboard bench for riscv_hwloop_regs (N_REGSETS = 2). Each step
// drives inputs just after a rising edge and queues the outputs expected at
// the following falling edge; a monitor pops and compares there.
// ---------------------------------------------------------------------------
module tb_riscv_hwloop_regs;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_id;
  logic        id_valid;
  logic        hwlp_jump;
  logic [31:0] hwlp_target;
  logic [1:0]  hwlp_done;

  riscv_hwloop_regs_if #(.N_REGSETS(2), .RID_W(1)) csr_if ();

  riscv_hwloop_regs #(
    .N_REGSETS (2),
    .RID_W     (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .csr_if        (csr_if),
    .pc_id_i       (pc_id),
    .id_valid_i    (id_valid),
    .hwlp_jump_o   (hwlp_jump),
    .hwlp_target_o (hwlp_target)
`ifdef HWLP_EVENT_COUNT_EN
    ,
    .hwlp_done_o   (hwlp_done)
`endif
  );

`ifndef HWLP_EVENT_COUNT_EN
  assign hwlp_done = 2'b00;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             jump;
    logic [31:0]      target;
    logic [1:0][31:0] s;
    logic [1:0][31:0] e;
    logic [1:0][31:0] c;
    logic [1:0]       done;
  } exp_t;

  exp_t sb[$];

  // Hand-maintained expected register contents, updated after each step.
  logic [1:0][31:0] es, ee, ec;

  int  tests = 0;
  int  fails = 0;
  bit  stim_done = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic rst_val, input logic [2:0] we,
                      input logic rid, input logic [31:0] data, input logic [31:0] pc,
                      input logic v, input logic j, input logic [31:0] t,
                      input logic [1:0] d);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n             = rst_val;
    csr_if.hwlp_we    = we;
    csr_if.hwlp_regid = rid;
    csr_if.hwlp_data  = data;
    pc_id             = pc;
    id_valid          = v;
    x.name   = nm;
    x.jump   = j;
    x.target = t;
    x.s      = es;
    x.e      = ee;
    x.c      = ec;
    x.done   = d;
    sb.push_back(x);
  endtask

  // Monitor: compare at the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      check({x.name, "/jump"},   {31'd0, hwlp_jump},     {31'd0, x.jump});
      check({x.name, "/target"}, hwlp_target,            x.target);
      check({x.name, "/start0"}, csr_if.hwlp_start[0],   x.s[0]);
      check({x.name, "/start1"}, csr_if.hwlp_start[1],   x.s[1]);
      check({x.name, "/end0"},   csr_if.hwlp_end[0],     x.e[0]);
      check({x.name, "/end1"},   csr_if.hwlp_end[1],     x.e[1]);
      check({x.name, "/cnt0"},   csr_if.hwlp_cnt[0],     x.c[0]);
      check({x.name, "/cnt1"},   csr_if.hwlp_cnt[1],     x.c[1]);
`ifdef HWLP_EVENT_COUNT_EN
      check({x.name, "/done"},   {30'd0, hwlp_done},     {30'd0, x.done});
`endif
    end else if (stim_done) begin
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n             = 1'b0;
    csr_if.hwlp_we    = 3'b000;
    csr_if.hwlp_regid = 1'b0;
    csr_if.hwlp_data  = 32'd0;
    pc_id             = 32'd0;
    id_valid          = 1'b0;
    es = '0; ee = '0; ec = '0;
    #22 rst_n = 1'b1;

    // Reset state
    step("reset_idle", 1, 3'b000, 0, 32'h0, 32'h0, 0, 0, 32'h0, 2'b00);

    // Single loop: start 0x100 (bit 0 written as 1, must read 0), end 0x10C, cnt 3
    step("wr_s0", 1, 3'b001, 0, 32'h101, 32'h0, 0, 0, 32'h0, 2'b00);
    es[0] = 32'h100;
    step("wr_e0", 1, 3'b010, 0, 32'h10C, 32'h0, 0, 0, 32'h0, 2'b00);
    ee[0] = 32'h10C;
    step("wr_c0", 1, 3'b100, 0, 32'd3, 32'h0, 0, 0, 32'h0, 2'b00);
    ec[0] = 32'd3;
    step("pass1", 1, 3'b000, 0, 32'h0, 32'h10C, 1, 1, 32'h100, 2'b00);
    ec[0] = 32'd2;
    step("pass2", 1, 3'b000, 0, 32'h0, 32'h10C, 1, 1, 32'h100, 2'b00);
    ec[0] = 32'd1;
    step("pass3", 1, 3'b000, 0, 32'h0, 32'h10C, 1, 0, 32'h0, 2'b00);
    ec[0] = 32'd0;
    // cnt == 0 at end address: inactive, no wrap; done pulse from pass 3
    step("cnt0_hit", 1, 3'b000, 0, 32'h0, 32'h10C, 1, 0, 32'h0, 2'b01);
    step("done_clr", 1, 3'b000, 0, 32'h0, 32'h10C, 0, 0, 32'h0, 2'b00);

    // Nested loops sharing end 0x120
    step("n_e0", 1, 3'b010, 0, 32'h120, 32'h0, 0, 0, 32'h0, 2'b00);
    ee[0] = 32'h120;
    step("n_c0", 1, 3'b100, 0, 32'd2, 32'h0, 0, 0, 32'h0, 2'b00);
    ec[0] = 32'd2;
    step("n_s1", 1, 3'b001, 1, 32'h200, 32'h0, 0, 0, 32'h0, 2'b00);
    es[1] = 32'h200;
    step("n_e1", 1, 3'b010, 1, 32'h120, 32'h0, 0, 0, 32'h0, 2'b00);
    ee[1] = 32'h120;
    step("n_c1", 1, 3'b100, 1, 32'd2, 32'h0, 0, 0, 32'h0, 2'b00);
    ec[1] = 32'd2;
    step("nest_hit1", 1, 3'b000, 0, 32'h0, 32'h120, 1, 1, 32'h100, 2'b00);
    ec[0] = 32'd1;
    // id_valid low at end address: no jump, no decrement
    step("nest_novalid", 1, 3'b000, 0, 32'h0, 32'h120, 0, 0, 32'h0, 2'b00);
    // Inner loop exits; outer set must not act this cycle
    step("nest_exit0", 1, 3'b000, 0, 32'h0, 32'h120, 1, 0, 32'h0, 2'b00);
    ec[0] = 32'd0;
    // Count write to set 1 during its own decrementing match: jump from old count
    step("wr_vs_dec", 1, 3'b100, 1, 32'd5, 32'h120, 1, 1, 32'h200, 2'b01);
    ec[1] = 32'd5;
    step("after_wr", 1, 3'b000, 0, 32'h0, 32'h120, 0, 0, 32'h0, 2'b00);

    // Reset mid-loop with the PC sitting at the end address
    step("wr_c0_4", 1, 3'b100, 0, 32'd4, 32'h0, 0, 0, 32'h0, 2'b00);
    ec[0] = 32'd4;
    step("rst_pre", 1, 3'b000, 0, 32'h0, 32'h120, 1, 1, 32'h100, 2'b00);
    es = '0; ee = '0; ec = '0;
    step("rst_assert", 0, 3'b000, 0, 32'h0, 32'h120, 1, 0, 32'h0, 2'b00);
    step("rst_hold",   0, 3'b000, 0, 32'h0, 32'h120, 1, 0, 32'h0, 2'b00);
    step("rst_release", 1, 3'b000, 0, 32'h0, 32'h120, 1, 0, 32'h0, 2'b00);
    step("post_rst",   1, 3'b000, 0, 32'h0, 32'h120, 1, 0, 32'h0, 2'b00);

    stim_done = 1'b1;
  end

endmodule
